inv_mixcolumn_iter: RTL

INV_MIXCOLUMN_ITER -- requirements
Module: inv_mixcolumn_iter

---
 rtl/inv_mixcolumn_iter_if.sv | 27 ++
 rtl/inv_mixcolumn_iter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/inv_mixcolumn_iter_if.sv
// rtl/inv_mixcolumn_iter_if.sv - valid/ready handshake bundle for the iterative InvMixColumns block
interface inv_mixcolumn_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/inv_mixcolumn_iter.sv
// rtl/inv_mixcolumn_iter.sv - AES InvMixColumns, one column per cycle through a single datapath
module inv_mixcolumn_iter (
    input  logic                 clk,
    input  logic                 rst,
    inv_mixcolumn_iter_if.slave  bus,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [1:0]   cnt;
    logic [127:0] in_reg;
    logic [127:0] out_reg;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [7:0]   col_in  [4];
    logic [7:0]   col_out [4];

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Higher powers of x are plain xtime chains; constants are sums of them.
    function automatic logic [7:0] mul09(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Column cnt of the latched state feeds the one shared column transform.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            col_in[r] = in_reg[32*r + 8*int'(cnt) +: 8];
        end
        for (int r = 0; r < 4; r++) begin
            col_out[r] = mul0e(col_in[r])
                       ^ mul0b(col_in[(r + 1) % 4])
                       ^ mul0d(col_in[(r + 2) % 4])
                       ^ mul09(col_in[(r + 3) % 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            in_reg      <= 128'h0;
            out_reg     <= 128'h0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_reg     <= bus.in_data;
                        cnt        <= 2'd0;
                        state      <= BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                BUSY: begin
                    for (int r = 0; r < 4; r++) begin
                        out_reg[32*r + 8*int'(cnt) +: 8] <= col_out[r];
                    end
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= 2'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_reg;
    assign busy          = busy_q;

endmodule
